imem_load_controller: RTL and testbench
=======================================

// Module: imem_load_controller
// PURPOSE
//   Sequences the loading of the word-addressed instruction memory from a streaming source,
//   replacing hard-coded initialisation. Holds the core in stall while loading.
//   After loading, passes the core's fetch address through to the memory read port.
//   Flags fetches beyond the loaded program. Sits between the boot source, the memory and the PC.
// PARAMETERS
//   DEPTH   64  number of 32-bit instruction words in memory
//   ADDR_W  6   memory word-address width, = clog2(DEPTH)
//   DATA_W  32  instruction word width
// PORTS
//   clk        in   1         single clock; all state changes on rising edge
//   reset      in   1         asynchronous, active-low; 0 forces reset state immediately
//   start      in   1         one-cycle pulse: begin a load of load_len words
//   load_len   in   ADDR_W+1  word count of program, sampled only on accepted start
//   in_valid   in   1         source has a word on in_data
//   in_data    in   DATA_W    instruction word from source
//   in_ready   out  1         controller accepts in_data this cycle
//   mem_we     out  1         write strobe to instruction memory
//   mem_waddr  out  ADDR_W    memory write word address
//   mem_wdata  out  DATA_W    memory write data
//   fetch_addr in   32        word address from PC (word, not byte, addressed)
//   mem_raddr  out  ADDR_W    memory read word address
//   cpu_stall  out  1         1 = core must not advance PC
//   done       out  1         program loaded, core running
//   len_err    out  1         sticky: start with load_len > DEPTH was rejected
//   fetch_oob  out  1         sticky: fetch_addr >= loaded length while running
// BEHAVIOUR
//   States: IDLE, LOAD, RUN. Reset (reset=0): state=IDLE, wptr=0, len_q=0, len_err=0,
//     fetch_oob=0; outputs in_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, mem_raddr=0,
//     cpu_stall=1, done=0.
//   IDLE: cpu_stall=1. On start:
//     load_len > DEPTH -> set len_err, stay IDLE.
//     load_len == 0 -> RUN next cycle, len_q=0.
//     else -> LOAD, len_q=load_len, wptr=0.
//   LOAD: in_ready=1, cpu_stall=1. Handshake = in_valid & in_ready.
//     The handshake write is combinational in the same cycle: mem_we=1, mem_waddr=wptr, mem_wdata=in_data.
//     wptr increments on each handshake.
//     The handshake with wptr==len_q-1 is the last word; the next cycle is RUN and in_ready drops.
//     Words never exceed len_q, so wptr never wraps. start is ignored in LOAD.
//     in_valid low -> no write, no state change, no timeout.
//   RUN: done=1, cpu_stall=0, in_ready=0, mem_we=0. mem_raddr=fetch_addr[ADDR_W-1:0], combinational.
//     fetch_addr >= len_q (full 32-bit compare) sets fetch_oob on the clock edge; it holds until reset.
//     mem_raddr still passes the truncated address.
//     start in RUN: reload using the IDLE rules. If accepted, LOAD next cycle with done=0 and cpu_stall=1.
//     Rejected (len > DEPTH): set len_err, stay RUN.
//   mem_raddr=0 outside RUN.
//   len_err clears only on reset.
//   Reset mid-LOAD: immediate return to IDLE. Partially written words stay in memory,
//     but the controller regards them as invalid.
//   cpu_stall is asserted from reset release until the first cycle in RUN.
// TESTING
//   1. Reset, start with load_len=3, feed words A,B,C back-to-back
//      -> mem_we on 3 cycles at addr 0,1,2; RUN with done=1 and cpu_stall=0 the cycle after C.
//   2. load_len=4, in_valid toggles 1,0,1,1,0,1 -> exactly 4 writes at addresses 0..3;
//      no write on in_valid=0 cycles; stall until the 4th write.
//   3. start with load_len=65 -> len_err=1, state IDLE, no writes.
//      start with load_len=0 -> RUN next cycle, done=1.
//   4. RUN with len_q=3: fetch_addr=2 -> mem_raddr=2, fetch_oob=0.
//      fetch_addr=3 -> fetch_oob=1 next edge, still 1 at fetch_addr=0.
//   5. Assert reset=0 after 2 of 5 words are loaded -> all outputs at reset values immediately.
//      Then a new start loads from address 0.
//   6. In RUN, start with load_len=2 -> done=0 and cpu_stall=1 next cycle; 2 writes at addresses 0,1; RUN again.

Source files
------------

// File: rtl/imem_load_controller.sv
// Instruction-memory boot loader: streams load_len words into the word-addressed
// instruction memory while stalling the core, then passes fetch addresses through.
module imem_load_controller #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [31:0]       fetch_addr,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              cpu_stall,
  output logic              done,
  output logic              len_err,
  output logic              fetch_oob
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_wptr;
  logic [ADDR_W:0]     r_len_q;
  logic                r_len_err;
  logic                r_fetch_oob;

  logic                w_start_ok;
  logic                w_len_bad;
  logic                w_accept;
  logic                w_reject;
  logic                w_hs;
  logic                w_last;
  logic                w_fetch_beyond;

  function automatic logic len_too_big(input logic [ADDR_W:0] len);
    return len > LP_DEPTH;
  endfunction

  assign w_start_ok     = start && (r_state != ST_LOAD);
  assign w_len_bad      = len_too_big(load_len);
  assign w_last         = ({1'b0, r_wptr} == (r_len_q - 1'b1));
  // Full-width compare: high fetch bits must count, not just the truncated index.
  assign w_fetch_beyond = (fetch_addr >= {{(32-ADDR_W-1){1'b0}}, r_len_q});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_hs         = 1'b0;
    in_ready     = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = '0;
    mem_wdata    = '0;
    mem_raddr    = '0;
    cpu_stall    = 1'b1;
    done         = 1'b0;

    if (w_start_ok) begin
      if (w_len_bad) begin
        w_reject = 1'b1;
      end else begin
        w_accept = 1'b1;
      end
    end

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = (load_len == '0) ? ST_RUN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_hs      = 1'b1;
          mem_we    = 1'b1;
          mem_waddr = r_wptr;
          mem_wdata = in_data;
          if (w_last) begin
            w_next_state = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        cpu_stall = 1'b0;
        done      = 1'b1;
        mem_raddr = fetch_addr[ADDR_W-1:0];
        if (w_accept && (load_len != '0)) begin
          w_next_state = ST_LOAD;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // A zero-length start still records len_q=0, so every later fetch counts as beyond.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr      <= '0;
      r_len_q     <= '0;
      r_len_err   <= 1'b0;
      r_fetch_oob <= 1'b0;
    end else begin
      if (w_reject) begin
        r_len_err <= 1'b1;
      end
      if (w_accept) begin
        r_len_q <= load_len;
        r_wptr  <= '0;
      end else if (w_hs) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if ((r_state == ST_RUN) && w_fetch_beyond) begin
        r_fetch_oob <= 1'b1;
      end
    end
  end

  assign len_err   = r_len_err;
  assign fetch_oob = r_fetch_oob;

endmodule

// File: tb/tb_imem_load_controller.sv
// Randomised bench for imem_load_controller against a mode/count level reference model.
module tb_imem_load_controller;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   load_len = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [31:0]       fetch_addr = '0;
  logic [ADDR_W-1:0] mem_raddr;
  logic              cpu_stall;
  logic              done;
  logic              len_err;
  logic              fetch_oob;

  imem_load_controller #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .fetch_addr(fetch_addr), .mem_raddr(mem_raddr), .cpu_stall(cpu_stall),
    .done(done), .len_err(len_err), .fetch_oob(fetch_oob)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode 0=idle 1=loading 2=running, plus word counts.
  int          m_mode;
  int          m_len;
  int          m_count;
  bit          m_err;
  bit          m_oob;
  logic [31:0] m_mem [DEPTH];
  bit          m_wr  [DEPTH];
  logic [31:0] t_mem [DEPTH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_len   = 0;
    m_count = 0;
    m_err   = 0;
    m_oob   = 0;
  endtask

  task automatic check_outputs();
    bit ld;
    bit run;
    ld  = (m_mode == 1);
    run = (m_mode == 2);
    chk("in_ready", 32'(in_ready), 32'(ld));
    chk("mem_we", 32'(mem_we), 32'(ld && in_valid));
    if (ld && in_valid) begin
      chk("mem_waddr", 32'(mem_waddr), 32'(m_count));
      chk("mem_wdata", mem_wdata, in_data);
    end
    chk("mem_raddr", 32'(mem_raddr), run ? 32'(fetch_addr % DEPTH) : 32'd0);
    chk("cpu_stall", 32'(cpu_stall), 32'(!run));
    chk("done", 32'(done), 32'(run));
    chk("len_err", 32'(len_err), 32'(m_err));
    chk("fetch_oob", 32'(fetch_oob), 32'(m_oob));
    if (mem_we === 1'b1) t_mem[mem_waddr] = mem_wdata;
  endtask

  task automatic model_edge(input bit s, input int len, input bit v,
                            input logic [31:0] d, input logic [31:0] fa);
    if (m_mode == 1) begin
      if (v) begin
        m_mem[m_count] = d;
        m_wr[m_count]  = 1'b1;
        m_count++;
        if (m_count == m_len) m_mode = 2;
      end
    end else begin
      if (m_mode == 2 && longint'(fa) >= longint'(m_len)) m_oob = 1;
      if (s) begin
        if (len > DEPTH) begin
          m_err = 1;
        end else if (len == 0) begin
          m_mode = 2;
          m_len  = 0;
        end else begin
          m_mode  = 1;
          m_len   = len;
          m_count = 0;
        end
      end
    end
  endtask

  task automatic cyc(input bit s, input int len, input bit v,
                     input logic [31:0] d, input logic [31:0] fa);
    start      = s;
    load_len   = len[ADDR_W:0];
    in_valid   = v;
    in_data    = d;
    fetch_addr = fa;
    #1;
    check_outputs();
    @(posedge clk);
    model_edge(s, len, v, d, fa);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("rst_waddr", 32'(mem_waddr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int r;
    int len;
    for (int i = 0; i < DEPTH; i++) begin
      m_wr[i]  = 1'b0;
      m_mem[i] = '0;
      t_mem[i] = '0;
    end
    model_reset();
    @(negedge clk);
    do_reset();

    // Three words back-to-back, then run.
    cyc(1, 3, 0, 0, 0);
    cyc(0, 0, 1, 32'hAAAA_0001, 0);
    cyc(0, 0, 1, 32'hBBBB_0002, 0);
    cyc(0, 0, 1, 32'hCCCC_0003, 0);
    cyc(0, 0, 0, 0, 1);

    // Gapped source with four words.
    do_reset();
    cyc(1, 4, 0, 0, 0);
    cyc(0, 0, 1, 32'h1000_0000, 0);
    cyc(0, 0, 0, 32'hDEAD_BEEF, 0);
    cyc(0, 0, 1, 32'h1000_0001, 0);
    cyc(0, 0, 1, 32'h1000_0002, 0);
    cyc(0, 0, 0, 32'hDEAD_BEEF, 0);
    cyc(0, 0, 1, 32'h1000_0003, 0);
    cyc(0, 0, 0, 0, 2);

    // Oversize rejected, zero length runs immediately.
    do_reset();
    cyc(1, 65, 1, 32'h5555_5555, 0);
    cyc(0, 0, 1, 32'h5555_5555, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Fetch bounds with three loaded words.
    do_reset();
    cyc(1, 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'h2000_0000 + 32'(i), 0);
    cyc(0, 0, 0, 0, 2);
    cyc(0, 0, 0, 0, 3);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Reset part way through a five-word load, then reload.
    do_reset();
    cyc(1, 5, 0, 0, 0);
    cyc(0, 0, 1, 32'h3000_0000, 0);
    cyc(0, 0, 1, 32'h3000_0001, 0);
    in_valid = 1'b1;
    do_reset();
    cyc(1, 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'h4000_0000 + 32'(i), 0);
    cyc(0, 0, 0, 0, 64);

    // Reload from run.
    cyc(1, 2, 0, 0, 1);
    cyc(0, 0, 1, 32'h5000_0000, 0);
    cyc(0, 0, 1, 32'h5000_0001, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 100, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        r = $urandom_range(0, 9);
        case (r)
          0:       len = 0;
          1:       len = 64;
          2:       len = 65;
          3:       len = $urandom_range(66, 127);
          default: len = $urandom_range(1, 12);
        endcase
        cyc(($urandom_range(0, 14) == 0), len, 1'($urandom_range(0, 1)), $urandom(),
            ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 15)));
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (m_wr[i]) chk("mem_content", t_mem[i], m_mem[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
